// File: rtl/demux_burst_dispatcher_pkg.sv
// Shared types and constants for the burst dispatcher: FSM encoding, sink count, counter sizing.
// Pure declarations, no latency or backpressure of its own.
package demux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  localparam int NUM_SINKS = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W_MAX = 8;

  // Beat counter width for a burst length in 1..255; a 1-word burst still needs one bit.
  function automatic int cnt_w(input int burst_len);
    return (burst_len <= 1) ? 1 : $clog2(burst_len);
  endfunction

endpackage

// File: rtl/demux_burst_dispatcher_if.sv
// Producer/consumer handshake bundle for the dispatcher, plus grant status.
// Wires only: zero latency; backpressure is carried by in_ready/out_ready.
interface demux_burst_dispatcher_if #(
  parameter int DATA_W = 8
);
  import demux_pkg::*;

  logic [NUM_SINKS-1:0] en;
  logic [DATA_W-1:0]    in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [DATA_W-1:0]    out_data;
  logic [NUM_SINKS-1:0] out_valid;
  logic [NUM_SINKS-1:0] out_ready;
  logic [SEL_W-1:0]     sel;
  logic                 busy;
  logic                 burst_done;

  modport master (
    output en, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, sel, busy, burst_done
  );

  modport slave (
    input  en, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, sel, busy, burst_done
  );

endinterface

// File: rtl/demux_burst_dispatcher_rr_pick4.sv
// Circular first-set search over a 4-bit enable mask, starting just after the last grant.
// Combinational, zero latency; no backpressure.
module rr_pick4
  import demux_pkg::*;
(
  input  logic [NUM_SINKS-1:0] en,
  input  logic [SEL_W-1:0]     last,
  output logic [SEL_W-1:0]     idx,
  output logic                 any
);

  logic [SEL_W-1:0] cand;

  // Walk offsets from far to near so the nearest enabled sink after last wins.
  always_comb begin
    idx  = '0;
    cand = '0;
    any  = |en;
    for (int k = NUM_SINKS - 1; k >= 0; k--) begin
      cand = last + SEL_W'(k + 1);
      if (en[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/demux_burst_dispatcher.sv
// Round-robin burst dispatcher: one producer stream granted to one of four sinks for BURST_LEN words.
// Data path is combinational (0 cycles); a stalled granted sink deasserts in_ready, other sinks are ignored.
module demux_burst_dispatcher
  import demux_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_burst_dispatcher_if.slave bus
);

  localparam int CW = cnt_w(BURST_LEN);

  localparam logic [0:0] IDLE = ST_IDLE;
  localparam logic [0:0] XFER = ST_XFER;

  logic [0:0]       state;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] last_q;
  logic [CW-1:0]    cnt;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             in_xfer;
  logic             beat;
  logic             last_beat;

  rr_pick4 u_pick (
    .en   (bus.en),
    .last (last_q),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  assign in_xfer   = (state == XFER);
  assign beat      = in_xfer && bus.in_valid && bus.out_ready[sel_q];
  assign last_beat = beat && (cnt == CW'(BURST_LEN - 1));

  // en is only looked at while IDLE, so the grant survives mask changes mid-burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel_q  <= '0;
      last_q <= SEL_W'(NUM_SINKS - 1);
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && pick_any) begin
            sel_q  <= pick_idx;
            last_q <= pick_idx;
            cnt    <= '0;
            state  <= XFER;
          end
        end
        XFER: begin
          if (last_beat) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (beat) begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.out_data   = DATA_W'(bus.in_data);
  assign bus.out_valid  = in_xfer ? (NUM_SINKS'(bus.in_valid) << sel_q) : '0;
  assign bus.in_ready   = in_xfer && bus.out_ready[sel_q];
  assign bus.sel        = sel_q;
  assign bus.busy       = in_xfer;
  assign bus.burst_done = last_beat;

endmodule
